mem_port_arbiter: RTL and testbench

- Shares one single-ported backing memory between the processor's instruction-fetch port and data port.
- Sits between the processor's Icache/Dcache buses and a common memory interface.
- Generates per-port miss (stall) signals and sequences each access with a req/ack handshake.
- Fair round-robin arbitration; a watchdog aborts hung accesses.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the processor-side fetch/data buses and the shared memory bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_miss;

  logic                  d_en;
  logic                  d_rw;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_miss;

  logic                  m_req;
  logic                  m_rw;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_ack;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  bus_err;

  modport slave (
    input  i_req, i_addr, d_en, d_rw, d_addr, d_wdata, m_ack, m_rdata,
    output i_data, i_miss, d_rdata, d_miss, m_req, m_rw, m_addr, m_wdata, bus_err
  );

  modport master (
    output i_req, i_addr, d_en, d_rw, d_addr, d_wdata, m_ack, m_rdata,
    input  i_data, i_miss, d_rdata, d_miss, m_req, m_rw, m_addr, m_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and
// data ports, with req/ack sequencing and a watchdog that aborts hung accesses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  m_req_q, m_req_d;
  logic                  m_rw_q, m_rw_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  bus_err_q, bus_err_d;
  logic                  grant;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      owner_q   <= PORT_I;
      last_q    <= PORT_I;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    bus_err_d = 1'b0;
    // With both ports pending, the one not served last wins.
    grant     = (bus.i_req && bus.d_en) ? ~last_q : bus.d_en;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.i_req || bus.d_en) begin
          owner_d   = grant;
          last_d    = grant;
          state_d   = S_BUSY;
          m_req_d   = 1'b1;
          m_addr_d  = (grant == PORT_D) ? bus.d_addr : bus.i_addr;
          m_rw_d    = (grant == PORT_D) ? bus.d_rw : 1'b0;
          m_wdata_d = (grant == PORT_D) ? bus.d_wdata : '0;
        end
      end
      S_BUSY: begin
        if (bus.m_ack) begin
          m_req_d = 1'b0;
          state_d = S_RESP;
          if (owner_q == PORT_I) begin
            i_data_d = bus.m_rdata;
          end else if (!m_rw_q) begin
            d_rdata_d = bus.m_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog abort: read results are forced to zero.
          m_req_d   = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_RESP;
          if (owner_q == PORT_I) begin
            i_data_d = '0;
          end else if (!m_rw_q) begin
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.i_miss = bus.i_req & ~((state_q == S_RESP) && (owner_q == PORT_I));
    bus.d_miss = bus.d_en  & ~((state_q == S_RESP) && (owner_q == PORT_D));
  end

  assign bus.i_data  = i_data_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_req   = m_req_q;
  assign bus.m_rw    = m_rw_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized transactions against a transaction-level model of
// the arbiter: who wins, what appears on the memory bus, and what retires.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic        exp_last;
  logic [31:0] exp_i_data;
  logic [31:0] exp_d_rdata;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_last    = 1'b0;
    exp_i_data  = '0;
    exp_d_rdata = '0;
  endtask

  // One access from the IDLE cycle through RESP and back to IDLE.
  // ack_delay >= TO means memory never answers.
  task automatic run_txn(input logic ireq, input logic den, input logic drw,
                         input logic [31:0] iaddr, input logic [31:0] daddr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_delay);
    logic        win;
    logic [31:0] eaddr;
    logic        erw;
    bit          timed_out;
    bus.i_req   = ireq;
    bus.d_en    = den;
    bus.d_rw    = drw;
    bus.i_addr  = iaddr;
    bus.d_addr  = daddr;
    bus.d_wdata = wdata;
    #1;
    chk("idle_i_miss", bus.i_miss, ireq);
    chk("idle_d_miss", bus.d_miss, den);
    win      = (ireq && den) ? ~exp_last : den;
    eaddr    = win ? daddr : iaddr;
    erw      = win & drw;
    exp_last = win;
    timed_out = (ack_delay >= TO);
    step();
    for (int k = 0; k < TO; k++) begin
      chk("busy_m_req", bus.m_req, 1'b1);
      chk("busy_m_addr", bus.m_addr, eaddr);
      chk("busy_m_rw", bus.m_rw, erw);
      if (erw) chk("busy_m_wdata", bus.m_wdata, wdata);
      chk("busy_owner_miss", win ? bus.d_miss : bus.i_miss, 1'b1);
      if (k == 0) begin
        bus.i_addr  = $urandom;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      if (k == ack_delay) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = rdata;
      end
      step();
      bus.m_ack   = 1'b0;
      bus.m_rdata = $urandom;
      if (k == ack_delay) break;
    end
    if (!win) exp_i_data = timed_out ? 32'h0 : rdata;
    else if (!erw) exp_d_rdata = timed_out ? 32'h0 : rdata;
    chk("resp_m_req", bus.m_req, 1'b0);
    chk("resp_bus_err", bus.bus_err, timed_out);
    chk("resp_i_data", bus.i_data, exp_i_data);
    chk("resp_d_rdata", bus.d_rdata, exp_d_rdata);
    chk("resp_owner_miss", win ? bus.d_miss : bus.i_miss, 1'b0);
    chk("resp_other_miss", win ? bus.i_miss : bus.d_miss, win ? ireq : den);
    $display("txn port=%s addr=0x%08h rw=%0d ack_delay=%0d timeout=%0d i_data=0x%08h d_rdata=0x%08h",
             win ? "D" : "I", eaddr, erw, ack_delay, timed_out, bus.i_data, bus.d_rdata);
    if (win) bus.d_en = 1'b0;
    else bus.i_req = 1'b0;
    step();
    chk("idle_bus_err", bus.bus_err, 1'b0);
    chk("idle_m_req", bus.m_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ir, de;
    int   dly;
    bus.i_req = 0; bus.i_addr = 0; bus.d_en = 0; bus.d_rw = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.m_ack = 0; bus.m_rdata = 0;
    model_reset();

    // Reset values; misses follow requests even in reset.
    #2;
    chk("rst_m_req", bus.m_req, 1'b0);
    chk("rst_bus_err", bus.bus_err, 1'b0);
    chk("rst_i_data", bus.i_data, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_m_rw", bus.m_rw, 1'b0);
    bus.i_req = 1'b1;
    #1;
    chk("rst_i_miss_follows", bus.i_miss, 1'b1);
    bus.i_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Single fetch, single write, read then a timed-out read.
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    run_txn(0, 1, 1, 32'h0, 32'h100, 32'h1234, 32'h5555AAAA, 0);
    run_txn(0, 1, 0, 32'h0, 32'h104, 32'h0, 32'hCAFE0001, 2);
    run_txn(0, 1, 0, 32'h0, 32'h108, 32'h0, 32'h77777777, TO);

    // Stale ack while idle changes nothing.
    bus.m_ack = 1'b1;
    bus.m_rdata = 32'hBAADF00D;
    step();
    bus.m_ack = 1'b0;
    step();
    chk("stale_i_data", bus.i_data, exp_i_data);
    chk("stale_d_rdata", bus.d_rdata, exp_d_rdata);
    chk("stale_m_req", bus.m_req, 1'b0);
    chk("stale_bus_err", bus.bus_err, 1'b0);
    $display("txn stale_ack i_data=0x%08h d_rdata=0x%08h", bus.i_data, bus.d_rdata);

    // Contention from reset: D, I, D, I.
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++)
      run_txn(1, 1, 0, 32'h2000 + n, 32'h3000 + n, 32'h0, 32'hA0000000 + n, 0);

    // Randomized mix of ports, directions, ack latencies and aborts.
    for (int n = 0; n < 24; n++) begin
      ir  = 1'($urandom_range(0, 1));
      de  = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
      run_txn(ir, de, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom, dly);
    end

    // Asynchronous reset in the middle of BUSY.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h80;
    step();
    chk("arst_busy_m_req", bus.m_req, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_m_req", bus.m_req, 1'b0);
    chk("arst_m_addr", bus.m_addr, 32'h0);
    chk("arst_i_data", bus.i_data, 32'h0);
    chk("arst_i_miss", bus.i_miss, 1'b1);
    $display("txn async_reset m_req=%0d", bus.m_req);
    model_reset();
    step();
    rst_n = 1'b1;
    run_txn(1, 0, 0, 32'h84, 32'h0, 32'h0, 32'h0BADC0DE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
